// File: rtl/vga_pkg.sv
// Shared constants for the VGA text pixel generator: display modes, the
// 16-entry 3-3-2 palette, cursor colour and black.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BLANK = 2'd0,
    MODE_TEXT  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_BARS  = 2'd3
  } vga_mode_e;

  localparam logic [7:0] BLACK     = 8'h00;
  localparam logic [7:0] CUR_COLOR = 8'h1F;

  // CGA-like colour set packed as RRRGGGBB
  localparam logic [7:0] PALETTE [16] = '{
    8'h00, 8'h02, 8'h10, 8'h12, 8'h80, 8'h82, 8'h88, 8'hB6,
    8'h49, 8'h4B, 8'h5D, 8'h5F, 8'hED, 8'hEF, 8'hFC, 8'hFF
  };

endpackage

// File: rtl/vga_blink_timer.sv
// Cursor blink timer: counts frameTick pulses and toggles phase every
// BLINK_FRAMES frames. phase resets to 1 so the cursor starts visible.
module vga_blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frameTick,
  output logic phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (frameTick) begin
      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_text_bitgen.sv
// Three-stage VGA pixel generator (text / solid / bars) with cursor box.
// Define VGA_CURSOR_BLINK_EN to gate the cursor with a frame-based blink timer.
module vga_text_bitgen
  import vga_pkg::*;
#(
  parameter int RGB_W        = 8,
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int CUR_R        = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              bright,
  input  logic [9:0]                        hCount,
  input  logic [9:0]                        vCount,
  input  logic                              hsyncIn,
  input  logic                              vsyncIn,
  input  logic                              frameTick,
  input  logic [1:0]                        mode,
  input  logic [RGB_W-1:0]                  bgColor,
  input  logic [9:0]                        curX,
  input  logic [9:0]                        curY,
  output logic [$clog2(COLS*ROWS)-1:0]      charAddr,
  input  logic [15:0]                       charData,
  output logic [8+$clog2(GLYPH_H)-1:0]      glyphAddr,
  input  logic [GLYPH_W-1:0]                glyphRow,
  output logic [RGB_W-1:0]                  rgb,
  output logic                              hsyncOut,
  output logic                              vsyncOut
);

  localparam int GX_W   = $clog2(GLYPH_W);
  localparam int GY_W   = $clog2(GLYPH_H);
  localparam int ADDR_W = $clog2(COLS*ROWS);

  localparam logic [9:0]        COLS_L = 10'(COLS);
  localparam logic [9:0]        ROWS_L = 10'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [GX_W-1:0]   GX_MAX = GX_W'(GLYPH_W - 1);
  localparam logic signed [10:0] CUR_R_S = 11'(CUR_R);

  logic [9:0]        colIdx, rowIdx;
  logic              onGrid0, hit0;
  logic signed [10:0] dx, dy;

  logic [GX_W-1:0]   glyphX1, glyphX2;
  logic [GY_W-1:0]   gLine1;
  logic              onGrid1, bright1, hs1, vs1, hit1;
  logic              onGrid2, bright2, hs2, vs2, hit2;
  vga_mode_e         mode1, mode2;
  logic [RGB_W-1:0]  bg1, bg2;
  logic [2:0]        bar1, bar2;
  logic [7:0]        attr2;
  logic              cursorOn, pixel;
  logic [RGB_W-1:0]  nextRgb;

  // S0: cell lookup and cursor box test; 11-bit signed math avoids wrap at 0/1023
  always_comb begin
    colIdx   = hCount >> GX_W;
    rowIdx   = vCount >> GY_W;
    onGrid0  = (colIdx < COLS_L) && (rowIdx < ROWS_L);
    charAddr = onGrid0 ? (ADDR_W'(rowIdx) * COLS_A + ADDR_W'(colIdx)) : '0;
    dx       = $signed({1'b0, hCount}) - $signed({1'b0, curX});
    dy       = $signed({1'b0, vCount}) - $signed({1'b0, curY});
    hit0     = (dx >= -CUR_R_S) && (dx <= CUR_R_S) && (dy >= -CUR_R_S) && (dy <= CUR_R_S);
  end

  assign glyphAddr = {charData[7:0], gLine1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyphX1 <= '0; gLine1 <= '0; onGrid1 <= 1'b0; bright1 <= 1'b0;
      hs1 <= 1'b1; vs1 <= 1'b1; hit1 <= 1'b0; mode1 <= MODE_BLANK;
      bg1 <= '0; bar1 <= '0;
      glyphX2 <= '0; onGrid2 <= 1'b0; bright2 <= 1'b0;
      hs2 <= 1'b1; vs2 <= 1'b1; hit2 <= 1'b0; mode2 <= MODE_BLANK;
      bg2 <= '0; bar2 <= '0; attr2 <= '0;
      rgb <= '0; hsyncOut <= 1'b1; vsyncOut <= 1'b1;
    end else begin
      glyphX1 <= hCount[GX_W-1:0];
      gLine1  <= vCount[GY_W-1:0];
      onGrid1 <= onGrid0;
      bright1 <= bright;
      hs1     <= hsyncIn;
      vs1     <= vsyncIn;
      hit1    <= hit0;
      mode1   <= vga_mode_e'(mode);
      bg1     <= bgColor;
      bar1    <= hCount[9:7];
      glyphX2 <= glyphX1;
      onGrid2 <= onGrid1;
      bright2 <= bright1;
      hs2     <= hs1;
      vs2     <= vs1;
      hit2    <= hit1;
      mode2   <= mode1;
      bg2     <= bg1;
      bar2    <= bar1;
      attr2   <= charData[15:8];
      rgb      <= nextRgb;
      hsyncOut <= hs2;
      vsyncOut <= vs2;
    end
  end

`ifdef VGA_CURSOR_BLINK_EN
  vga_blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk      (clk),
    .rst_n    (rst_n),
    .frameTick(frameTick),
    .phase    (cursorOn)
  );
`else
  logic unusedTick;
  assign unusedTick = frameTick ^ (BLINK_FRAMES == 0);
  assign cursorOn   = 1'b1;
`endif

  // S2: colour priority -- blanking, cursor, then the selected mode
  always_comb begin
    pixel   = glyphRow[GX_MAX - glyphX2];
    nextRgb = RGB_W'(BLACK);
    if (!bright2) begin
      nextRgb = RGB_W'(BLACK);
    end else if (hit2 && cursorOn) begin
      nextRgb = RGB_W'(CUR_COLOR);
    end else begin
      case (mode2)
        MODE_BLANK: nextRgb = RGB_W'(BLACK);
        MODE_SOLID: nextRgb = bg2;
        MODE_BARS:  nextRgb = RGB_W'(PALETTE[{1'b0, bar2}]);
        MODE_TEXT:  nextRgb = !onGrid2 ? bg2 :
                              pixel ? RGB_W'(PALETTE[attr2[7:4]]) : RGB_W'(PALETTE[attr2[3:0]]);
        default:    nextRgb = RGB_W'(BLACK);
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_bitgen.sv
// Directed self-checking bench for vga_text_bitgen with char RAM / glyph ROM models.
module tb_vga_text_bitgen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bright;
  logic [9:0]  hCount, vCount;
  logic        hsyncIn, vsyncIn, frameTick;
  logic [1:0]  mode;
  logic [7:0]  bgColor;
  logic [9:0]  curX, curY;
  logic [11:0] charAddr;
  logic [15:0] charData;
  logic [11:0] glyphAddr;
  logic [7:0]  glyphRow;
  logic [7:0]  rgb;
  logic        hsyncOut, vsyncOut;

  int totalChecks = 0;
  int badChecks   = 0;

  localparam logic [7:0] PAL [16] = '{
    8'h00, 8'h02, 8'h10, 8'h12, 8'h80, 8'h82, 8'h88, 8'hB6,
    8'h49, 8'h4B, 8'h5D, 8'h5F, 8'hED, 8'hEF, 8'hFC, 8'hFF
  };
  localparam logic [7:0] CYAN = 8'h1F;
  localparam logic [7:0] BG   = 8'h25;
  localparam logic [7:0] GLYPH_A0 = 8'b1010_0110;

  logic [15:0] charMem  [0:4095];
  logic [7:0]  glyphMem [0:4095];

  typedef struct {
    string      tag;
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;
  exp_t pipeQ[$];

  vga_text_bitgen #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bright(bright), .hCount(hCount), .vCount(vCount),
    .hsyncIn(hsyncIn), .vsyncIn(vsyncIn), .frameTick(frameTick), .mode(mode),
    .bgColor(bgColor), .curX(curX), .curY(curY), .charAddr(charAddr),
    .charData(charData), .glyphAddr(glyphAddr), .glyphRow(glyphRow),
    .rgb(rgb), .hsyncOut(hsyncOut), .vsyncOut(vsyncOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    charData <= charMem[charAddr];
    glyphRow <= glyphMem[glyphAddr];
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] want);
    totalChecks++;
    if (got !== want) begin
      badChecks++;
      $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Drive one pixel, clock it in, and check the pixel sampled two edges earlier.
  task automatic applyStimulus(input string tag, input logic [9:0] h, input logic [9:0] v,
                               input logic b, input logic [1:0] m, input logic [7:0] eRgb);
    exp_t e;
    hCount = h; vCount = v; bright = b; mode = m;
    @(posedge clk);
    #1;
    e.tag = tag; e.rgb = eRgb; e.hs = hsyncIn; e.vs = vsyncIn;
    pipeQ.push_back(e);
    if (pipeQ.size() == 3) begin
      e = pipeQ.pop_front();
      checkOutput({e.tag, ".rgb"}, {8'h0, rgb}, {8'h0, e.rgb});
      checkOutput({e.tag, ".hs"}, {15'h0, hsyncOut}, {15'h0, e.hs});
      checkOutput({e.tag, ".vs"}, {15'h0, vsyncOut}, {15'h0, e.vs});
    end
  endtask

  task automatic tickFrame();
    frameTick = 1'b1;
    applyStimulus("tick", 10'd0, 10'd0, 1'b0, 2'd2, 8'h00);
    frameTick = 1'b0;
    applyStimulus("idle", 10'd0, 10'd0, 1'b0, 2'd2, 8'h00);
  endtask

  initial begin
    logic [7:0] pat;
    for (int i = 0; i < 4096; i++) begin
      charMem[i]  = 16'h0000;
      glyphMem[i] = 8'h00;
    end
    charMem[82] = 16'hF041;
    charMem[83] = 16'h4141;
    glyphMem[{8'h41, 4'd0}] = GLYPH_A0;

    rst_n = 1'b0; frameTick = 1'b0; bgColor = BG; curX = 10'd1000; curY = 10'd1000;
    hsyncIn = 1'b1; vsyncIn = 1'b1; bright = 1'b0; mode = 2'd0; hCount = '0; vCount = '0;

    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      hCount = 10'($urandom); vCount = 10'($urandom); bright = 1'b1;
      mode = 2'($urandom); hsyncIn = 1'($urandom); vsyncIn = 1'($urandom);
      @(posedge clk); #1;
      checkOutput("rst.rgb", {8'h0, rgb}, 16'h0000);
      checkOutput("rst.hs", {15'h0, hsyncOut}, 16'h0001);
      checkOutput("rst.vs", {15'h0, vsyncOut}, 16'h0001);
    end
    hsyncIn = 1'b1; vsyncIn = 1'b1;
    rst_n = 1'b1;
    applyStimulus("post_rst", 10'd0, 10'd0, 1'b1, 2'd2, BG);
    applyStimulus("post_rst2", 10'd5, 10'd0, 1'b1, 2'd2, BG);

    // text mode: cell (2,1) and (3,1), glyph line 0 of 'A'
    hCount = 10'd16; vCount = 10'd16; #1;
    checkOutput("charAddr82", {4'h0, charAddr}, 16'd82);
    pat = GLYPH_A0;
    for (int i = 0; i < 8; i++)
      applyStimulus($sformatf("txtF0_%0d", i), 10'(16 + i), 10'd16, 1'b1, 2'd1,
                    pat[7-i] ? PAL[15] : PAL[0]);
    for (int i = 0; i < 8; i++)
      applyStimulus($sformatf("txt41_%0d", i), 10'(24 + i), 10'd16, 1'b1, 2'd1,
                    pat[7-i] ? PAL[4] : PAL[1]);

    // off-grid
    hCount = 10'd640; vCount = 10'd16; #1;
    checkOutput("charAddrOff", {4'h0, charAddr}, 16'd0);
    applyStimulus("offH", 10'd640, 10'd16, 1'b1, 2'd1, BG);
    applyStimulus("offV", 10'd16, 10'd480, 1'b1, 2'd1, BG);
    applyStimulus("offDark", 10'd640, 10'd16, 1'b0, 2'd1, 8'h00);

    // cursor at origin
    curX = 10'd0; curY = 10'd0;
    applyStimulus("cur0_0", 10'd0, 10'd0, 1'b1, 2'd1, CYAN);
    applyStimulus("cur0_2", 10'd2, 10'd0, 1'b1, 2'd1, CYAN);
    applyStimulus("cur2_2", 10'd2, 10'd2, 1'b1, 2'd1, CYAN);
    applyStimulus("cur3_0", 10'd3, 10'd0, 1'b1, 2'd1, 8'h00);
    applyStimulus("cur0_3", 10'd0, 10'd3, 1'b1, 2'd1, 8'h00);
    applyStimulus("cur1023", 10'd1023, 10'd0, 1'b1, 2'd2, BG);

    // cursor at (300,300) across modes
    curX = 10'd300; curY = 10'd300;
    applyStimulus("c300_m2", 10'd298, 10'd300, 1'b1, 2'd2, CYAN);
    applyStimulus("c303_m2", 10'd303, 10'd300, 1'b1, 2'd2, BG);
    applyStimulus("c302_m0", 10'd302, 10'd302, 1'b1, 2'd0, CYAN);
    applyStimulus("c297_m0", 10'd297, 10'd300, 1'b1, 2'd0, 8'h00);
    applyStimulus("c298_m3", 10'd300, 10'd298, 1'b1, 2'd3, CYAN);
    applyStimulus("c300_dark", 10'd300, 10'd300, 1'b0, 2'd2, 8'h00);

    // colour bars
    for (int k = 0; k < 8; k++)
      applyStimulus($sformatf("bar%0d", k), 10'(k * 128), 10'd16, 1'b1, 2'd3, PAL[k]);

    // mode change mid-line
    curX = 10'd1000; curY = 10'd1000;
    for (int i = 0; i < 8; i++)
      applyStimulus($sformatf("mchg%0d", i), 10'(100 + i), 10'd0, 1'b1,
                    (i < 4) ? 2'd1 : 2'd2, (i < 4) ? 8'h00 : BG);

    // syncs delayed by three clocks
    for (int i = 0; i < 6; i++) begin
      hsyncIn = (i % 2) == 1;
      vsyncIn = !(i == 2 || i == 3);
      applyStimulus($sformatf("sync%0d", i), 10'd0, 10'd0, 1'b0, 2'd0, 8'h00);
    end
    hsyncIn = 1'b1; vsyncIn = 1'b1;

    // blink: two frames hide the cursor, two more show it
    curX = 10'd0; curY = 10'd0;
    applyStimulus("blinkA", 10'd1, 10'd1, 1'b1, 2'd2, CYAN);
    tickFrame();
    tickFrame();
`ifdef VGA_CURSOR_BLINK_EN
    applyStimulus("blinkB", 10'd1, 10'd1, 1'b1, 2'd2, BG);
`else
    applyStimulus("blinkB", 10'd1, 10'd1, 1'b1, 2'd2, CYAN);
`endif
    tickFrame();
    tickFrame();
    applyStimulus("blinkC", 10'd1, 10'd1, 1'b1, 2'd2, CYAN);

    // async reset in the middle of a line
    curX = 10'd1000; curY = 10'd1000; hsyncIn = 1'b0; vsyncIn = 1'b0;
    for (int i = 0; i < 4; i++)
      applyStimulus("preArst", 10'(200 + i), 10'd40, 1'b1, 2'd2, BG);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst.rgb", {8'h0, rgb}, 16'h0000);
    checkOutput("arst.hs", {15'h0, hsyncOut}, 16'h0001);
    checkOutput("arst.vs", {15'h0, vsyncOut}, 16'h0001);
    pipeQ.delete();
    @(posedge clk); #1;
    checkOutput("arst.hold", {8'h0, rgb}, 16'h0000);
    hsyncIn = 1'b1; vsyncIn = 1'b1;
    rst_n = 1'b1;
    applyStimulus("postArst0", 10'd210, 10'd40, 1'b1, 2'd2, BG);
    applyStimulus("postArst1", 10'd211, 10'd40, 1'b1, 2'd0, 8'h00);
    for (int i = 0; i < 3; i++)
      applyStimulus("drain", 10'd0, 10'd0, 1'b0, 2'd0, 8'h00);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
